// File: rtl/signed_sar_search.sv
// Successive-approximation search for a signed two's-complement value.
// Drives trial operands into an external signed comparator, one bit per
// compare transaction, MSB first. An internal offset-binary code keeps the
// search monotonic in unsigned terms; the MSB flip maps it to signed.
module signed_sar_search #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] trial,
  output logic             cmp_req,
  input  logic             cmp_valid,
  input  logic             cmp_ge,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             timeout
);

  localparam int IW = $clog2(WIDTH);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GAP
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] code, code_nxt;
  logic [WIDTH-1:0] result_nxt;
  logic [IW-1:0]    bit_idx, bit_idx_nxt;
  logic [TW-1:0]    tcnt, tcnt_nxt;
  logic             done_nxt, timeout_nxt;

  // Offset binary -> two's complement: flipping the MSB maps unsigned order onto signed order.
  function automatic logic [WIDTH-1:0] to_signed(input logic [WIDTH-1:0] c);
    return {~c[WIDTH-1], c[WIDTH-2:0]};
  endfunction

  // Outputs decoded directly from the state register.
  always_comb begin
    cmp_req = (state == REQ);
    busy    = (state != IDLE);
  end

  // Next-state and datapath update: one bit resolved per accepted compare.
  always_comb begin
    state_nxt   = state;
    code_nxt    = code;
    bit_idx_nxt = bit_idx;
    tcnt_nxt    = tcnt;
    result_nxt  = result;
    done_nxt    = 1'b0;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          code_nxt            = '0;
          code_nxt[WIDTH-1]   = 1'b1;
          bit_idx_nxt         = IW'(WIDTH - 1);
          tcnt_nxt            = '0;
          state_nxt           = REQ;
        end
      end
      REQ: begin
        if (cmp_valid) begin
          if (!cmp_ge) code_nxt[bit_idx] = 1'b0;
          if (bit_idx == '0) begin
            result_nxt = to_signed(code_nxt);
            done_nxt   = 1'b1;
            state_nxt  = IDLE;
          end else begin
            code_nxt[bit_idx - 1'b1] = 1'b1;
            bit_idx_nxt              = bit_idx - 1'b1;
            state_nxt                = GAP;
          end
        end else if (TIMEOUT != 0) begin
          if (tcnt == TLAST) begin
            timeout_nxt = 1'b1;
            state_nxt   = IDLE;
          end else begin
            tcnt_nxt = tcnt + 1'b1;
          end
        end
      end
      GAP: begin
        tcnt_nxt  = '0;
        state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers; trial is registered from the next code so it is glitch-free.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= IDLE;
      code    <= '0;
      bit_idx <= '0;
      tcnt    <= '0;
      trial   <= '0;
      result  <= '0;
      done    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      code    <= code_nxt;
      bit_idx <= bit_idx_nxt;
      tcnt    <= tcnt_nxt;
      trial   <= to_signed(code_nxt);
      result  <= result_nxt;
      done    <= done_nxt;
      timeout <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_signed_sar_search.sv
// Bench for signed_sar_search: models the target-holding comparator and
// scoreboards the expected signed result per search.
module tb_signed_sar_search;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       start;
  logic [7:0] trial;
  logic       cmp_req;
  logic       cmp_valid;
  logic       cmp_ge;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  // Comparator model state
  logic signed [7:0] target = '0;
  int                delay  = 0;
  bit                model_en = 1'b0;
  int                req_cnt = 0;
  logic [7:0]        held = '0;
  bit                unstable = 1'b0;
  logic [7:0]        trial_log[$];
  logic [7:0]        exp_q[$];

  signed_sar_search #(.WIDTH(8), .TIMEOUT(64)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .start    (start),
    .trial    (trial),
    .cmp_req  (cmp_req),
    .cmp_valid(cmp_valid),
    .cmp_ge   (cmp_ge),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .timeout  (timeout)
  );

  always #5 sys_clk = ~sys_clk;

  // Comparator: answers after 'delay' cycles of cmp_req; noise on the flag when not valid.
  always @(negedge sys_clk) begin
    if (model_en && cmp_req) begin
      if (req_cnt > 0 && trial !== held) unstable = 1'b1;
      held = trial;
      if (req_cnt == delay) begin
        cmp_valid = 1'b1;
        cmp_ge    = ($signed(target) >= $signed(trial));
        trial_log.push_back(trial);
      end else begin
        cmp_valid = 1'b0;
        cmp_ge    = 1'($urandom_range(0, 1));
      end
      req_cnt++;
    end else begin
      cmp_valid = model_en ? 1'($urandom_range(0, 1)) : 1'b0;
      cmp_ge    = 1'($urandom_range(0, 1));
      req_cnt   = 0;
    end
  end

  task automatic launch(input logic signed [7:0] t, input int d);
    target   = t;
    delay    = d;
    model_en = 1'b1;
    exp_q.push_back(t);
    trial_log.delete();
    unstable = 1'b0;
    start    = 1'b1;
    @(posedge sys_clk); #1;
    start    = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 400) begin
      @(posedge sys_clk); #1;
      cyc++;
      if (done) break;
    end
    if (!done) cyc = -1;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    start     = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    checks++;
    if ({trial, result, cmp_req, busy, done, timeout} !== 20'h0) begin
      errors++;
      $display("FAIL reset_state: got trial=%h result=%h req=%b busy=%b done=%b to=%b, want all 0",
               trial, result, cmp_req, busy, done, timeout);
    end
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
  endtask

  task automatic test_basic();
    int cyc;
    logic [7:0] exp;
    logic [7:0] seq[8] = '{8'd0, 8'd64, 8'd32, 8'd48, 8'd40, 8'd36, 8'd38, 8'd37};
    launch(8'sd37, 0);
    wait_done(cyc);
    exp = exp_q.pop_front();
    checks++;
    if (cyc !== 15) begin
      errors++; $display("FAIL basic_latency: got %0d edges, want 15", cyc);
    end
    checks++;
    if (result !== exp) begin
      errors++; $display("FAIL basic_result: got %h, want %h", result, exp);
    end
    checks++;
    if (trial_log.size() != 8) begin
      errors++; $display("FAIL basic_trial_count: got %0d, want 8", trial_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (trial_log[i] !== seq[i]) begin
          errors++; $display("FAIL basic_trial[%0d]: got %0d, want %0d", i, trial_log[i], seq[i]);
        end
      end
    end
    @(posedge sys_clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_done_pulse: got done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_extremes();
    int cyc;
    logic [7:0] exp;
    logic signed [7:0] tg[6] = '{-8'sd128, 8'sd127, -8'sd1, 8'sd0, -8'sd127, 8'sd1};
    for (int i = 0; i < 6; i++) begin
      launch(tg[i], 0);
      wait_done(cyc);
      exp = exp_q.pop_front();
      checks++;
      if (cyc !== 15 || result !== exp) begin
        errors++; $display("FAIL extreme_%0d: got result=%h at %0d, want %h at 15", i, result, cyc, exp);
      end
      @(posedge sys_clk); #1;
    end
  endtask

  task automatic test_delayed();
    int cyc;
    logic [7:0] exp;
    launch(-8'sd77, 3);
    wait_done(cyc);
    exp = exp_q.pop_front();
    checks++;
    if (cyc !== 39) begin
      errors++; $display("FAIL delayed_latency: got %0d, want 39", cyc);
    end
    checks++;
    if (result !== 8'hB3 || result !== exp) begin
      errors++; $display("FAIL delayed_result: got %h, want b3", result);
    end
    checks++;
    if (unstable) begin
      errors++; $display("FAIL delayed_trial_stable: got unstable=1, want 0");
    end
    @(posedge sys_clk); #1;
  endtask

  task automatic test_timeout();
    int cyc = 0;
    bit saw_done = 1'b0;
    logic [7:0] prev;
    prev     = result;
    model_en = 1'b0;
    start    = 1'b1;
    @(posedge sys_clk); #1;
    start    = 1'b0;
    while (cyc < 200) begin
      @(posedge sys_clk); #1;
      cyc++;
      if (done) saw_done = 1'b1;
      if (timeout) break;
    end
    checks++;
    if (!timeout || cyc !== 64) begin
      errors++; $display("FAIL timeout_pulse: got timeout=%b at %0d, want 1 at 64", timeout, cyc);
    end
    checks++;
    if (busy !== 1'b0 || result !== prev || saw_done) begin
      errors++; $display("FAIL timeout_state: got busy=%b result=%h done_seen=%b, want 0 %h 0",
                         busy, result, saw_done, prev);
    end
    @(posedge sys_clk); #1;
    checks++;
    if (timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_width: got %b, want 0", timeout);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [7:0] exp;
    launch(8'sd50, 0);
    repeat (3) @(posedge sys_clk);
    #1;
    start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    wait_done(cyc);
    exp = exp_q.pop_front();
    checks++;
    if (cyc + 4 !== 15 || result !== exp) begin
      errors++; $display("FAIL restart_ignored: got result=%h at %0d, want %h at 15", result, cyc + 4, exp);
    end
    // start coincident with the done pulse
    launch(-8'sd99, 1);
    checks++;
    if (cmp_req !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL coincident_start: got req=%b busy=%b, want 1 1", cmp_req, busy);
    end
    wait_done(cyc);
    exp = exp_q.pop_front();
    checks++;
    if (cyc !== 23 || result !== exp) begin
      errors++; $display("FAIL coincident_result: got %h at %0d, want %h at 23", result, cyc, exp);
    end
    @(posedge sys_clk); #1;
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic [7:0] exp;
    launch(8'sd90, 0);
    repeat (6) @(posedge sys_clk);
    #1;
    checks++;
    if (cmp_req !== 1'b1) begin
      errors++; $display("FAIL mid_in_req: got req=%b, want 1", cmp_req);
    end
    #2;
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({trial, result, cmp_req, busy, done, timeout} !== 20'h0) begin
      errors++;
      $display("FAIL mid_reset_async: got trial=%h result=%h req=%b busy=%b, want all 0",
               trial, result, cmp_req, busy);
    end
    void'(exp_q.pop_front());
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    launch(-8'sd5, 0);
    wait_done(cyc);
    exp = exp_q.pop_front();
    checks++;
    if (cyc !== 15 || result !== exp) begin
      errors++; $display("FAIL mid_fresh_search: got %h at %0d, want %h at 15", result, cyc, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    start     = 1'b0;
    cmp_valid = 1'b0;
    cmp_ge    = 1'b0;
    test_reset();
    test_basic();
    test_extremes();
    test_delayed();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
